tmr_scrub_reg: RTL

Triplicated, self-scrubbing data register sitting on the fanout side of a triplicated path. It accepts a single (already voted) data word, holds it in three independent register copies, and drives the bitwise majority of those copies onto three output lanes. Every cycle the voted value is written back into all copies, correcting single-copy upsets. Per-lane mismatch counters and a sticky error flag report upsets to slow control. Fault-injection masks allow the bench and in-system self-test to corrupt individual copies.

---
 rtl/tmr_scrub_reg.sv | 95 +++++++++
 1 files changed

// File: rtl/tmr_scrub_reg.sv
// Triplicated self-scrubbing register: three copies, bitwise majority vote on
// all output lanes, per-copy mismatch counters and a sticky error flag.
module tmr_scrub_reg #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [WIDTH-1:0]     in,
  input  logic                 load,
  input  logic [WIDTH-1:0]     injA,
  input  logic [WIDTH-1:0]     injB,
  input  logic [WIDTH-1:0]     injC,
  input  logic                 clrErr,
  output logic [WIDTH-1:0]     outA,
  output logic [WIDTH-1:0]     outB,
  output logic [WIDTH-1:0]     outC,
  output logic [CNT_WIDTH-1:0] errCntA,
  output logic [CNT_WIDTH-1:0] errCntB,
  output logic [CNT_WIDTH-1:0] errCntC,
  output logic                 errSticky
);

  logic [WIDTH-1:0]     reg_a_q, reg_b_q, reg_c_q;
  logic [WIDTH-1:0]     reg_a_d, reg_b_d, reg_c_d;
  logic [CNT_WIDTH-1:0] cnt_a_q, cnt_b_q, cnt_c_q;
  logic [CNT_WIDTH-1:0] cnt_a_d, cnt_b_d, cnt_c_d;
  logic                 sticky_q, sticky_d;

  logic [WIDTH-1:0]     vote;
  logic [WIDTH-1:0]     base;
  logic                 mm_a, mm_b, mm_c;

  // Saturating counter step; clear wins over a same-cycle mismatch.
  function automatic logic [CNT_WIDTH-1:0] cnt_next(
    input logic [CNT_WIDTH-1:0] cnt,
    input logic                 mm,
    input logic                 clr
  );
    if (clr)                    return '0;
    else if (mm && cnt != '1)   return cnt + 1'b1;
    else                        return cnt;
  endfunction

  always_comb begin
    vote = (reg_a_q & reg_b_q) | (reg_b_q & reg_c_q) | (reg_a_q & reg_c_q);
    mm_a = |(reg_a_q ^ vote);
    mm_b = |(reg_b_q ^ vote);
    mm_c = |(reg_c_q ^ vote);

    // Scrub writes the vote back every cycle; injection masks sit on top.
    base    = load ? in : vote;
    reg_a_d = base ^ injA;
    reg_b_d = base ^ injB;
    reg_c_d = base ^ injC;

    cnt_a_d = cnt_next(cnt_a_q, mm_a, clrErr);
    cnt_b_d = cnt_next(cnt_b_q, mm_b, clrErr);
    cnt_c_d = cnt_next(cnt_c_q, mm_c, clrErr);

    sticky_d = sticky_q;
    if (clrErr)                    sticky_d = 1'b0;
    else if (mm_a | mm_b | mm_c)   sticky_d = 1'b1;
  end

  // NOTE: non-blocking assignments here so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      reg_a_q  <= '0;
      reg_b_q  <= '0;
      reg_c_q  <= '0;
      cnt_a_q  <= '0;
      cnt_b_q  <= '0;
      cnt_c_q  <= '0;
      sticky_q <= 1'b0;
    end else begin
      reg_a_q  <= reg_a_d;
      reg_b_q  <= reg_b_d;
      reg_c_q  <= reg_c_d;
      cnt_a_q  <= cnt_a_d;
      cnt_b_q  <= cnt_b_d;
      cnt_c_q  <= cnt_c_d;
      sticky_q <= sticky_d;
    end
  end

  assign outA      = vote;
  assign outB      = vote;
  assign outC      = vote;
  assign errCntA   = cnt_a_q;
  assign errCntB   = cnt_b_q;
  assign errCntC   = cnt_c_q;
  assign errSticky = sticky_q;

endmodule
